// File: rtl/operand_fetch.sv
// operand_fetch: reads two source registers, forwards in-flight results, stalls on load-use hazards
module operand_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs,
  input  logic [ADDR_WIDTH-1:0] in_rt,
  input  logic                  in_use_rs,
  input  logic                  in_use_rt,
  output logic                  rd_enable1,
  output logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [DATA_WIDTH-1:0] rd_data1,
  output logic                  rd_enable2,
  output logic [ADDR_WIDTH-1:0] rd_addr2,
  input  logic [DATA_WIDTH-1:0] rd_data2,
  input  logic                  ex_we,
  input  logic                  ex_is_load,
  input  logic [ADDR_WIDTH-1:0] ex_waddr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  input  logic                  mem_we,
  input  logic                  mem_is_load,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_op1,
  output logic [DATA_WIDTH-1:0] out_op2
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] rs_q, rt_q;
  logic                  use_rs_q, use_rt_q, valid_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q, op1_d, op2_d;
  logic                  accept, fetching, haz1, haz2, hazard;

  function automatic logic hit(input logic we, input logic [ADDR_WIDTH-1:0] waddr, input logic [ADDR_WIDTH-1:0] src);
    return we && waddr == src;
  endfunction

  function automatic logic live(input logic use_src, input logic [ADDR_WIDTH-1:0] src);
    return use_src && src != '0;
  endfunction

  assign in_ready = !reset && !flush && (state_q == IDLE || (state_q == VALID && out_ready));
  assign accept   = in_valid && in_ready;
  assign fetching = !reset && state_q == FETCH;

  assign rd_enable1 = accept ? in_use_rs : fetching && use_rs_q;
  assign rd_enable2 = accept ? in_use_rt : fetching && use_rt_q;
  assign rd_addr1   = accept ? in_rs : fetching ? rs_q : '0;
  assign rd_addr2   = accept ? in_rt : fetching ? rt_q : '0;

  assign haz1   = live(use_rs_q, rs_q) && (hit(ex_we && ex_is_load, ex_waddr, rs_q) || hit(mem_we && mem_is_load, mem_waddr, rs_q));
  assign haz2   = live(use_rt_q, rt_q) && (hit(ex_we && ex_is_load, ex_waddr, rt_q) || hit(mem_we && mem_is_load, mem_waddr, rt_q));
  assign hazard = haz1 || haz2;

  assign op1_d = !live(use_rs_q, rs_q) ? '0 :
                 hit(ex_we, ex_waddr, rs_q)   ? ex_wdata  :
                 hit(mem_we, mem_waddr, rs_q) ? mem_wdata :
                 hit(wb_we, wb_waddr, rs_q)   ? wb_wdata  : rd_data1;
  assign op2_d = !live(use_rt_q, rt_q) ? '0 :
                 hit(ex_we, ex_waddr, rt_q)   ? ex_wdata  :
                 hit(mem_we, mem_waddr, rt_q) ? mem_wdata :
                 hit(wb_we, wb_waddr, rt_q)   ? wb_wdata  : rd_data2;

  assign out_valid = valid_q;
  assign out_op1   = op1_q;
  assign out_op2   = op2_q;

  // request FSM: latch on accept, wait out load hazards, hold result until taken
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      use_rs_q <= 1'b0;
      use_rt_q <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          rs_q     <= in_rs;
          rt_q     <= in_rt;
          use_rs_q <= in_use_rs;
          use_rt_q <= in_use_rt;
          state_q  <= FETCH;
        end
        FETCH: if (!hazard) begin
          op1_q   <= op1_d;
          op2_q   <= op2_d;
          valid_q <= 1'b1;
          state_q <= VALID;
        end
        VALID: if (out_ready) begin
          valid_q <= 1'b0;
          state_q <= accept ? FETCH : IDLE;
          if (accept) begin
            rs_q     <= in_rs;
            rt_q     <= in_rt;
            use_rs_q <= in_use_rs;
            use_rt_q <= in_use_rt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
